// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - condition-code types, constants and classify/branch helpers
package cc_pkg;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N     = 3'b100;
  localparam nzp_t NZP_Z     = 3'b010;
  localparam nzp_t NZP_P     = 3'b001;
  localparam nzp_t NZP_RESET = NZP_Z;

  // Widest bus classify accepts; callers zero-extend and pass their real width.
  localparam int unsigned CLASSIFY_W = 64;

  function automatic nzp_t classify(input logic [CLASSIFY_W-1:0] value,
                                    input int unsigned width);
    logic [CLASSIFY_W-1:0] sign_mask;
    sign_mask = {{(CLASSIFY_W-1){1'b0}}, 1'b1} << (width - 1);
    if (value == '0)
      return NZP_Z;
    else if ((value & sign_mask) != '0)
      return NZP_N;
    else
      return NZP_P;
  endfunction

  function automatic logic branch_taken(input logic [2:0] cond, input nzp_t nzp);
    if (cond == 3'b000 || cond == 3'b111)
      return 1'b1;
    return (cond & nzp) != 3'b000;
  endfunction

endpackage

// File: rtl/cc_stack.sv
// rtl/cc_stack.sv - bounded LIFO of saved condition codes with sticky misuse flag
module cc_stack
  import cc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  nzp_t                       din,
  output nzp_t                       dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       err,
  output logic                       pop_ok
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  nzp_t          mem [DEPTH];
  logic          do_push;
  logic          bad;
  logic [LW-1:0] level_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~pop & ~full & ~reset;
  assign pop_ok   = pop & ~push & ~empty;
  // Simultaneous push/pop is treated as a conflict, never as a swap.
  assign bad      = (push & pop) | (push & full) | (pop & empty);
  assign level_m1 = level - LW'(1);
  assign wr_idx   = level[AW-1:0];
  assign rd_idx   = level_m1[AW-1:0];
  assign dout     = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      err   <= 1'b0;
    end else begin
      if (do_push)
        level <= level + LW'(1);
      else if (pop_ok)
        level <= level_m1;
      if (bad)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/cc_branch_unit.sv
// rtl/cc_branch_unit.sv - registered NZP/BEN unit with saved-NZP stack for interrupts
module cc_branch_unit
  import cc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic [DATA_W-1:0]                BUS,
  input  logic                             LD_CC,
  input  logic [15:0]                      IR,
  input  logic                             LD_BEN,
  input  logic                             CC_PUSH,
  input  logic                             CC_POP,
  output logic [2:0]                       NZP,
  output logic                             BEN,
  output logic [$clog2(STACK_DEPTH+1)-1:0] CC_LEVEL,
  output logic                             CC_FULL,
  output logic                             CC_EMPTY,
  output logic                             CC_ERR
);

  nzp_t stack_top;
  nzp_t bus_class;
  logic pop_ok;
  logic unused_ir;

  assign unused_ir = ^{IR[15:12], IR[8:0]};
  assign bus_class = classify(CLASSIFY_W'(BUS), DATA_W);

  cc_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk    (Clk),
    .reset  (Reset),
    .push   (CC_PUSH),
    .pop    (CC_POP),
    .din    (NZP),
    .dout   (stack_top),
    .level  (CC_LEVEL),
    .full   (CC_FULL),
    .empty  (CC_EMPTY),
    .err    (CC_ERR),
    .pop_ok (pop_ok)
  );

  // BEN reads the NZP register as it stands before this edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      NZP <= NZP_RESET;
      BEN <= 1'b0;
    end else begin
      if (pop_ok)
        NZP <= stack_top;
      else if (LD_CC)
        NZP <= bus_class;
      if (LD_BEN)
        BEN <= branch_taken(IR[11:9], NZP);
    end
  end

endmodule

// File: tb/tb_cc_branch_unit.sv
// tb/tb_cc_branch_unit.sv - directed and randomized checks of cc_branch_unit against a queue model
module tb_cc_branch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] BUS;
  logic        LD_CC;
  logic [15:0] IR;
  logic        LD_BEN;
  logic        CC_PUSH;
  logic        CC_POP;
  logic [2:0]  NZP;
  logic        BEN;
  logic [2:0]  CC_LEVEL;
  logic        CC_FULL;
  logic        CC_EMPTY;
  logic        CC_ERR;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  logic [2:0] m_nzp;
  logic       m_ben;
  logic       m_err;
  logic [2:0] m_q[$];

  cc_branch_unit #(.DATA_W(16), .STACK_DEPTH(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .BUS      (BUS),
    .LD_CC    (LD_CC),
    .IR       (IR),
    .LD_BEN   (LD_BEN),
    .CC_PUSH  (CC_PUSH),
    .CC_POP   (CC_POP),
    .NZP      (NZP),
    .BEN      (BEN),
    .CC_LEVEL (CC_LEVEL),
    .CC_FULL  (CC_FULL),
    .CC_EMPTY (CC_EMPTY),
    .CC_ERR   (CC_ERR)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: signed view of BUS, LIFO as a queue.
  always @(posedge Clk) begin
    logic [2:0] old_nzp;
    logic [2:0] new_nzp;
    logic [2:0] c;
    if (Reset) begin
      m_nzp = 3'b010;
      m_ben = 1'b0;
      m_err = 1'b0;
      m_q.delete();
    end else begin
      old_nzp = m_nzp;
      c = IR[11:9];
      if (LD_BEN)
        m_ben = (c == 3'd0 || c == 3'd7) ? 1'b1 : ((c & old_nzp) != 3'd0);
      if (!LD_CC)
        new_nzp = old_nzp;
      else if (BUS == 16'd0)
        new_nzp = 3'b010;
      else if ($signed(BUS) < 0)
        new_nzp = 3'b100;
      else
        new_nzp = 3'b001;
      if (CC_PUSH && CC_POP)
        m_err = 1'b1;
      else if (CC_PUSH) begin
        if (m_q.size() == 4) m_err = 1'b1;
        else m_q.push_back(old_nzp);
      end else if (CC_POP) begin
        if (m_q.size() == 0) m_err = 1'b1;
        else new_nzp = m_q.pop_back();
      end
      m_nzp = new_nzp;
    end
  end

  always @(negedge Clk) begin
    if (en) begin
      chk("m_nzp",   {29'd0, NZP},      {29'd0, m_nzp});
      chk("m_ben",   {31'd0, BEN},      {31'd0, m_ben});
      chk("m_level", {29'd0, CC_LEVEL}, m_q.size());
      chk("m_full",  {31'd0, CC_FULL},  {31'd0, m_q.size() == 4});
      chk("m_empty", {31'd0, CC_EMPTY}, {31'd0, m_q.size() == 0});
      chk("m_err",   {31'd0, CC_ERR},   {31'd0, m_err});
    end
  end

  task automatic step(input logic rst, input logic [15:0] bus, input logic ldcc,
                      input logic [2:0] cond, input logic ldben, input logic push,
                      input logic pop);
    @(negedge Clk);
    Reset   = rst;
    BUS     = bus;
    LD_CC   = ldcc;
    IR      = {4'h0, cond, 9'h000};
    LD_BEN  = ldben;
    CC_PUSH = push;
    CC_POP  = pop;
    @(posedge Clk);
    #1;
  endtask

  task automatic cc(input logic [15:0] bus);
    step(1'b0, bus, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ben_with(input logic [2:0] cond);
    step(1'b0, 16'h0, 1'b0, cond, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_cc(input logic [15:0] bus);
    step(1'b0, bus, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pop1;
    step(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [2:0] exp_pop [4];
    exp_pop[0] = 3'b001; exp_pop[1] = 3'b010; exp_pop[2] = 3'b100; exp_pop[3] = 3'b001;

    step(1'b1, 16'h1234, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
    en = 1'b1;
    step(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_nzp",   {29'd0, NZP}, 32'h2);
    chk("rst_ben",   {31'd0, BEN}, 32'h0);
    chk("rst_level", {29'd0, CC_LEVEL}, 32'h0);
    chk("rst_empty", {31'd0, CC_EMPTY}, 32'h1);
    chk("rst_full",  {31'd0, CC_FULL}, 32'h0);
    chk("rst_err",   {31'd0, CC_ERR}, 32'h0);

    cc(16'h0000); chk("cls_zero", {29'd0, NZP}, 32'h2);
    cc(16'h8000); chk("cls_neg",  {29'd0, NZP}, 32'h4);
    cc(16'h7FFF); chk("cls_pos",  {29'd0, NZP}, 32'h1);

    cc(16'h8000);
    ben_with(3'b011); chk("ben_011", {31'd0, BEN}, 32'h0);
    ben_with(3'b100); chk("ben_100", {31'd0, BEN}, 32'h1);
    ben_with(3'b011); chk("ben_011b", {31'd0, BEN}, 32'h0);
    ben_with(3'b000); chk("ben_000", {31'd0, BEN}, 32'h1);
    ben_with(3'b011);
    ben_with(3'b111); chk("ben_111", {31'd0, BEN}, 32'h1);
    cc(16'h7FFF);
    step(1'b0, 16'h0000, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("ben_prior_nzp", {31'd0, BEN}, 32'h0);
    chk("ben_prior_cc",  {29'd0, NZP}, 32'h2);
    ben_with(3'b010); chk("ben_next_cycle", {31'd0, BEN}, 32'h1);

    cc(16'h7FFF);
    push_cc(16'h0000);
    chk("push_nzp", {29'd0, NZP}, 32'h2);
    chk("push_lvl", {29'd0, CC_LEVEL}, 32'h1);
    pop1;
    chk("pop_nzp",   {29'd0, NZP}, 32'h1);
    chk("pop_lvl",   {29'd0, CC_LEVEL}, 32'h0);
    chk("pop_empty", {31'd0, CC_EMPTY}, 32'h1);
    chk("pop_err",   {31'd0, CC_ERR}, 32'h0);

    push_cc(16'h8000);
    push_cc(16'h0000);
    push_cc(16'h7FFF);
    push_cc(16'h8000);
    chk("fill_full", {31'd0, CC_FULL}, 32'h1);
    chk("fill_err",  {31'd0, CC_ERR}, 32'h0);
    push_cc(16'h0000);
    chk("over_lvl",  {29'd0, CC_LEVEL}, 32'h4);
    chk("over_full", {31'd0, CC_FULL}, 32'h1);
    chk("over_err",  {31'd0, CC_ERR}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      pop1;
      chk($sformatf("lifo_nzp%0d", i), {29'd0, NZP}, {29'd0, exp_pop[i]});
      chk($sformatf("lifo_lvl%0d", i), {29'd0, CC_LEVEL}, 32'(3 - i));
    end
    pop1;
    chk("under_nzp", {29'd0, NZP}, 32'h1);
    chk("under_err", {31'd0, CC_ERR}, 32'h1);

    step(1'b1, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    push_cc(16'h0001);
    push_cc(16'h0000);
    step(1'b0, 16'hFFFF, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
    chk("both_lvl", {29'd0, CC_LEVEL}, 32'h2);
    chk("both_nzp", {29'd0, NZP}, 32'h4);
    chk("both_err", {31'd0, CC_ERR}, 32'h1);
    ben_with(3'b100);
    push_cc(16'h0005);
    chk("pre_rst_lvl", {29'd0, CC_LEVEL}, 32'h3);
    step(1'b1, 16'h8000, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_nzp",   {29'd0, NZP}, 32'h2);
    chk("mid_rst_ben",   {31'd0, BEN}, 32'h0);
    chk("mid_rst_lvl",   {29'd0, CC_LEVEL}, 32'h0);
    chk("mid_rst_empty", {31'd0, CC_EMPTY}, 32'h1);
    chk("mid_rst_full",  {31'd0, CC_FULL}, 32'h0);
    chk("mid_rst_err",   {31'd0, CC_ERR}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] b;
      case ($urandom_range(3))
        0: b = 16'h0000;
        1: b = 16'h8000 | 16'($urandom);
        default: b = 16'($urandom);
      endcase
      step($urandom_range(99) == 0, b, $urandom_range(1), 3'($urandom),
           $urandom_range(1), $urandom_range(2) == 0, $urandom_range(2) == 0);
    end

    step(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_branch_unit.md
# cc_branch_unit

Registered condition-code and branch-enable unit for the LC-3 datapath, successor to the purely combinational NZP/BEN logic. Latches N/Z/P from a parametrised-width bus on LD_CC, registers BEN on LD_BEN, and keeps a bounded LIFO of saved condition codes for interrupt entry and RTI. Sits beside the register file, fed by the bus mux; outputs go to the control FSM and PSR logic.

## Interface
- DATA_W, 16: width of the bus value classified into N/Z/P (≥2)
- STACK_DEPTH, 4: saved-NZP entries (≥1)
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- BUS  in  DATA_W  value on the datapath bus
- LD_CC  in  1  load NZP from BUS this cycle
- IR  in  16  instruction register; IR[11:9] is the branch condition field
- LD_BEN  in  1  load BEN this cycle
- CC_PUSH  in  1  save current NZP (interrupt entry)
- CC_POP  in  1  restore NZP from top of stack (RTI)
- NZP  out  3  registered condition code, one-hot {N,Z,P}
- BEN  out  1  registered branch enable
- CC_LEVEL  out  $clog2(STACK_DEPTH+1)  occupied entries
- CC_FULL  out  1  CC_LEVEL == STACK_DEPTH
- CC_EMPTY  out  1  CC_LEVEL == 0
- CC_ERR  out  1  sticky overflow/underflow/conflict flag

## Operation
- Classification of BUS: all bits zero → 010; else BUS[DATA_W-1]=1 → 100; else → 001. NZP is always one-hot.
- Branch rule: BEN_next = 1 if IR[11:9] is 000 or 111, else 1 if (IR[11:9] & NZP) ≠ 0, else 0.
- LD_BEN evaluates against the NZP register value before this cycle's edge (not the same-cycle LD_CC result).
- Push: stack[level] ← current NZP (pre-update); level+1. Same-cycle LD_CC still loads the new value into NZP.
- Pop: NZP ← stack[level-1]; level-1. Pop overrides a same-cycle LD_CC.
- Push when full: entry dropped, level unchanged, CC_ERR ← 1.
- Pop when empty: NZP not restored (LD_CC applies if asserted), CC_ERR ← 1.
- CC_PUSH and CC_POP together: stack and level unchanged, no restore, LD_CC applies, CC_ERR ← 1.
- CC_ERR clears only on Reset.
- Reset (any cycle, including mid push/pop): NZP=010, BEN=0, CC_LEVEL=0, CC_EMPTY=1, CC_FULL=0, CC_ERR=0; stack contents don't-care; all other inputs ignored that cycle.

## Timing
- All outputs registered or decoded from registers only; no combinational path from inputs to outputs.
- LD_CC at edge k → NZP valid after edge k (1-cycle latency).
- LD_BEN at edge k → BEN valid after edge k; LD_CC at k then LD_BEN at k+1 sees the new NZP.
- Push/pop: CC_LEVEL, CC_FULL, CC_EMPTY update after the same edge; popped NZP visible after that edge.
- BEN, NZP hold when their load signals are low.
- Back-to-back push/pop every cycle supported, no bubbles.

## Structure
- Package cc_pkg: nzp_t (logic [2:0]), constants NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001, NZP_RESET=NZP_Z, function classify (parametrised width) and function branch_taken(cond, nzp).
- Sub-module cc_stack: LIFO of nzp_t, STACK_DEPTH entries, push/pop/level/full/empty/err ports; top level holds the NZP and BEN registers and priority logic.

## Test plan
- Reset then idle → NZP=010, BEN=0, CC_LEVEL=0, CC_EMPTY=1, CC_ERR=0.
- DATA_W=16: LD_CC with BUS=16'h0000, 16'h8000, 16'h7FFF → NZP 010, 100, 001 on successive cycles.
- NZP=100, IR[11:9]=011 with LD_BEN → BEN=0; IR[11:9]=100 → BEN=1; 000 and 111 → BEN=1; same-cycle LD_CC (BUS=0) with LD_BEN, IR[11:9]=010, prior NZP=001 → BEN=0.
- Push NZP=001, LD_CC BUS=0 same cycle → NZP=010, level=1; pop → NZP=001, level=0, CC_EMPTY=1.
- STACK_DEPTH=4: five pushes → level=4, CC_FULL=1, CC_ERR=1 on the fifth; four pops restore entries in reverse order; extra pop → NZP holds, CC_ERR stays 1.
- Push+pop same cycle with LD_CC BUS=16'hFFFF → level unchanged, NZP=100, CC_ERR=1; Reset mid-sequence at level 3 → all outputs at reset values next cycle.
